// File: rtl/psram_lcd_scan.sv
// psram_lcd_scan: pixel-clock raster generator that pops RGB565 words from the
// PSRAM read FIFO and drives a parallel RGB LCD (DE/HSYNC/VSYNC). On FIFO
// underrun it emits black pixels, counts the misses and keeps the raster going.
`timescale 1ns/1ps

module psram_lcd_scan #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    output logic        lcd_de,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b,
    output logic        frame_start,
    output logic [15:0] underflow_cnt
);

    localparam int unsigned CW = 11;

    localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   h_cnt;
    logic [CW-1:0]   v_cnt;

    logic            run_c;
    logic            active_c;
    logic            hsync_n_c;
    logic            vsync_n_c;
    logic            sof_c;

    logic            active_d;
    logic            hsync_n_d;
    logic            vsync_n_d;
    logic            taken_d;
    logic            sof_d;
    logic            pixel_ok_c;

    // Bit 16 of the FIFO word carries no pixel information.
    logic            fifo_q_unused;
    assign fifo_q_unused = fifo_q[16];

    // Raster position decode from the live counters.
    always_comb begin
        run_c      = (state == S_RUN);
        active_c   = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hsync_n_c  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vsync_n_c  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        sof_c      = active_c && (h_cnt == '0) && (v_cnt == '0);
        fifo_rdreq = run_c && active_c && !fifo_empty && !reset;
    end

    // Start-up FSM and free-running h/v counters; IDLE holds the raster at 0,0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (!fifo_empty) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        if (v_cnt == V_LAST) begin
                            v_cnt <= '0;
                        end else begin
                            v_cnt <= v_cnt + CW'(1);
                        end
                    end else begin
                        h_cnt <= h_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    h_cnt <= '0;
                    v_cnt <= '0;
                end
            endcase
        end
    end

    // Stage 1: delay timing by one clock so it lines up with the popped word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_d  <= 1'b0;
            hsync_n_d <= 1'b1;
            vsync_n_d <= 1'b1;
            taken_d   <= 1'b0;
            sof_d     <= 1'b0;
        end else if (run_c) begin
            active_d  <= active_c;
            hsync_n_d <= hsync_n_c;
            vsync_n_d <= vsync_n_c;
            taken_d   <= fifo_rdreq;
            sof_d     <= sof_c;
        end else begin
            active_d  <= 1'b0;
            hsync_n_d <= 1'b1;
            vsync_n_d <= 1'b1;
            taken_d   <= 1'b0;
            sof_d     <= 1'b0;
        end
    end

    // Saturating count of active pixels that found the FIFO empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_cnt <= '0;
        end else if (run_c && active_c && fifo_empty && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

    // LCD pins: stage-1 timing plus FIFO data, black when no word was popped.
    always_comb begin
        pixel_ok_c  = active_d && taken_d;
        lcd_de      = active_d;
        lcd_hsync   = hsync_n_d;
        lcd_vsync   = vsync_n_d;
        frame_start = sof_d;
        lcd_r       = pixel_ok_c ? fifo_q[15:11] : 5'd0;
        lcd_g       = pixel_ok_c ? fifo_q[10:5]  : 6'd0;
        lcd_b       = pixel_ok_c ? fifo_q[4:0]   : 5'd0;
    end

endmodule

// File: tb/tb_psram_lcd_scan.sv
// Testbench for psram_lcd_scan: small raster (8 x 5), model FIFO and a pixel
// scoreboard, plus a wide-raster instance for the underflow counter ceiling.
`timescale 1ns/1ps

module tb_psram_lcd_scan;

    logic        clk;
    logic        reset;
    logic [16:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic        lcd_de;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;
    logic        frame_start;
    logic [15:0] underflow_cnt;
    logic [15:0] pix;

    // Wide-raster instance used only for counter saturation.
    logic [16:0] sat_fifo_q;
    logic        sat_empty;
    logic        sat_unused_rdreq;
    logic        sat_unused_de;
    logic        sat_unused_hs;
    logic        sat_unused_vs;
    logic [4:0]  sat_unused_r;
    logic [5:0]  sat_unused_g;
    logic [4:0]  sat_unused_b;
    logic        sat_unused_fs;
    logic [15:0] sat_cnt;

    int checks;
    int failures;
    logic [15:0] mem[$];
    logic [15:0] sb[$];
    logic        rd_prev;

    assign pix = {lcd_r, lcd_g, lcd_b};

    psram_lcd_scan #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk(clk), .reset(reset), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq), .lcd_de(lcd_de), .lcd_hsync(lcd_hsync),
        .lcd_vsync(lcd_vsync), .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .frame_start(frame_start), .underflow_cnt(underflow_cnt)
    );

    psram_lcd_scan #(
        .H_ACTIVE(2000), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(40), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) sat_dut (
        .clk(clk), .reset(reset), .fifo_q(sat_fifo_q), .fifo_empty(sat_empty),
        .fifo_rdreq(sat_unused_rdreq), .lcd_de(sat_unused_de), .lcd_hsync(sat_unused_hs),
        .lcd_vsync(sat_unused_vs), .lcd_r(sat_unused_r), .lcd_g(sat_unused_g),
        .lcd_b(sat_unused_b), .frame_start(sat_unused_fs), .underflow_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: FIFO pops on the request seen before the edge, then inputs update.
    task automatic step(input bit force_empty);
        @(posedge clk);
        #1;
        if (rd_prev && (mem.size() > 0)) begin
            fifo_q = {1'b1, mem.pop_front()};
        end
        fifo_empty = (mem.size() == 0) || force_empty;
        #1;
        rd_prev = fifo_rdreq;
    endtask

    // One 40-clock frame starting on the first-DE clock.
    task automatic run_frame(input bit pulse, input logic [15:0] exp_u);
        for (int k = 0; k < 40; k++) begin
            int hp;
            int vp;
            bit exp_de;
            logic [15:0] exp_pix;
            step(pulse && (k == 0));
            hp = k % 8;
            vp = k / 8;
            exp_de = (hp < 4) && (vp < 2);
            chk("de", 32'(lcd_de), 32'(exp_de));
            chk("hsync", 32'(lcd_hsync), 32'(!((hp == 5) || (hp == 6))));
            chk("vsync", 32'(lcd_vsync), 32'(vp != 3));
            chk("frame_start", 32'(frame_start), 32'(k == 0));
            if (exp_de) begin
                exp_pix = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
                chk("pixel", 32'(pix), 32'(exp_pix));
            end else begin
                chk("pixel_blank", 32'(pix), 32'd0);
            end
        end
        chk("underflow_cnt", 32'(underflow_cnt), 32'(exp_u));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rd_prev    = 1'b0;
        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_q     = 17'h0;
        sat_fifo_q = 17'h0;
        sat_empty  = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        chk("rst_de", 32'(lcd_de), 32'd0);
        chk("rst_hsync", 32'(lcd_hsync), 32'd1);
        chk("rst_vsync", 32'(lcd_vsync), 32'd1);
        chk("rst_pix", 32'(pix), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_ucnt", 32'(underflow_cnt), 32'd0);
        reset = 1'b0;

        // Idle with empty FIFO for 50 clocks.
        for (int i = 0; i < 50; i++) begin
            step(1'b0);
            chk("idle_rdreq", 32'(fifo_rdreq), 32'd0);
            chk("idle_de", 32'(lcd_de), 32'd0);
            chk("idle_hsync", 32'(lcd_hsync), 32'd1);
            chk("idle_vsync", 32'(lcd_vsync), 32'd1);
            chk("idle_ucnt", 32'(underflow_cnt), 32'd0);
        end

        // 14 words: frame 1 full (1..8), frame 2 six words then two misses.
        for (int i = 1; i <= 14; i++) begin
            mem.push_back(16'(i));
            sb.push_back(16'(i));
        end
        repeat (2) sb.push_back(16'h0);
        repeat (16) sb.push_back(16'h0);
        fifo_empty = 1'b0;
        rd_prev    = fifo_rdreq;
        step(1'b0);
        chk("start_rdreq", 32'(fifo_rdreq), 32'd1);
        chk("start_de", 32'(lcd_de), 32'd0);
        run_frame(1'b0, 16'd0);
        run_frame(1'b0, 16'd2);
        run_frame(1'b0, 16'd10);
        run_frame(1'b0, 16'd18);

        // Reset asserted mid line 1 of the next frame.
        repeat (10) step(1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_de", 32'(lcd_de), 32'd0);
        chk("mid_rst_hsync", 32'(lcd_hsync), 32'd1);
        chk("mid_rst_vsync", 32'(lcd_vsync), 32'd1);
        chk("mid_rst_rdreq", 32'(fifo_rdreq), 32'd0);
        chk("mid_rst_ucnt", 32'(underflow_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset   = 1'b0;
        rd_prev = fifo_rdreq;
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            chk("post_rst_de", 32'(lcd_de), 32'd0);
            chk("post_rst_rdreq", 32'(fifo_rdreq), 32'd0);
        end

        // Empty pulse at h_cnt=1 of line 0: one black pixel, no data lost.
        for (int i = 1; i <= 8; i++) mem.push_back(16'(16'hA000 + i));
        sb.push_back(16'hA001);
        sb.push_back(16'h0);
        for (int i = 2; i <= 7; i++) sb.push_back(16'(16'hA000 + i));
        sb.push_back(16'hA008);
        repeat (7) sb.push_back(16'h0);
        fifo_empty = 1'b0;
        rd_prev    = fifo_rdreq;
        step(1'b0);
        chk("restart_rdreq", 32'(fifo_rdreq), 32'd1);
        run_frame(1'b1, 16'd1);
        run_frame(1'b0, 16'd8);

        // Saturation on the wide raster (2000 active of 2003 per line).
        @(negedge clk);
        chk("sat_reset_cnt", 32'(sat_cnt), 32'd0);
        sat_empty = 1'b0;
        @(posedge clk);
        #1;
        sat_empty = 1'b1;
        repeat (2003 * 10) @(posedge clk);
        #1;
        chk("sat_10_lines", 32'(sat_cnt), 32'd20000);
        repeat (2003 * 22) @(posedge clk);
        #1;
        chk("sat_32_lines", 32'(sat_cnt), 32'd64000);
        repeat (2003) @(posedge clk);
        #1;
        chk("sat_33_lines", 32'(sat_cnt), 32'hFFFF);
        repeat (2003) @(posedge clk);
        #1;
        chk("sat_hold", 32'(sat_cnt), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
